bitcoin_mem_responder: RTL and testbench

Word-addressed memory responder and job sequencer for the serial Bitcoin hash core. It accepts a 19-word block header from a host stream and holds it in an internal RAM. It pulses the core's start, then serves the core's memory read/write requests at one-cycle read latency. When the core reports done, it streams the 16 resulting per-nonce H0 words back to the host. It is the memory-side counterpart of the core's mem_* master interface.

---
 rtl/bitcoin_mem_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_bitcoin_mem_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitcoin_mem_responder.sv
// bitcoin_mem_responder
//
// Memory-side partner of the serial Bitcoin hash core. A job runs as:
//   LOAD  : take 19 header words from the host into RAM[MSG_BASE..+18]
//   START : one-cycle core_start pulse, clear the sticky address error
//   ARM   : wait for the core to drop the done level left from the last job
//   RUN   : serve core reads/writes until core_done rises
//   DRAIN : stream RAM[OUT_BASE..+15] (H0 of each nonce) back to the host
//
// Handshakes (both host streams): a word moves on a rising clk edge where
// valid and ready are both high. A source holding valid keeps its data stable
// until that edge; ready may rise and fall freely and has no effect while
// valid is low.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   ld_valid/ld_data    host header stream in, ld_ready back-pressure out
//   rd_valid/rd_data    result stream out, rd_index = nonce index of rd_data,
//   rd_ready            host accepts the result word
//   job_done            one-cycle pulse after result 15 is taken
//   busy                high whenever a job is in flight (not LOAD)
//   err_addr            sticky: the core used an address >= DEPTH this job
//   core_start          one-cycle start pulse to the core
//   core_done           done level from the core
//   core_message_addr   constant MSG_BASE
//   core_output_addr    constant OUT_BASE
//   mem_we/mem_addr/mem_write_data  core memory master request
//   mem_read_data       registered read data, one-cycle latency
//   dbg_state           current FSM state for checkers
module bitcoin_mem_responder #(
  parameter int DEPTH    = 64,
  parameter int MSG_BASE = 0,
  parameter int OUT_BASE = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [3:0]  rd_index,
  input  logic        rd_ready,
  output logic        job_done,
  output logic        busy,
  output logic        err_addr,
  output logic        core_start,
  input  logic        core_done,
  output logic [15:0] core_message_addr,
  output logic [15:0] core_output_addr,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  ld_cnt_q, ld_cnt_d;
  logic [4:0]  dr_cnt_q, dr_cnt_d;
  logic        ld_ready_q, ld_ready_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [3:0]  rd_index_q, rd_index_d;
  logic        job_done_q, job_done_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic [31:0] mrd_q, mrd_d;

  // Single write port shared by host loads and core writes; the two never
  // overlap because core writes are only honoured in ARM/RUN.
  logic [31:0]   ram [DEPTH];
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;

  logic          addr_ok;
  logic [AW-1:0] core_idx;
  logic          core_active;
  logic [AW-1:0] ld_waddr;
  logic [AW-1:0] dr_raddr;

  assign addr_ok     = ({1'b0, mem_addr} < 17'(DEPTH));
  assign core_idx    = mem_addr[AW-1:0];
  assign core_active = (state_q == S_ARM) || (state_q == S_RUN);
  assign ld_waddr    = AW'(MSG_BASE) + AW'(ld_cnt_q);
  assign dr_raddr    = AW'(OUT_BASE) + AW'(dr_cnt_q[3:0]);

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    dr_cnt_d   = dr_cnt_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_index_d = rd_index_q;
    job_done_d = 1'b0;
    err_d      = err_q;
    ram_we     = 1'b0;
    ram_waddr  = core_idx;
    ram_wdata  = mem_write_data;

    // Core read port runs every cycle regardless of state; out-of-range
    // addresses read as zero rather than aliasing into the RAM.
    mrd_d = addr_ok ? ram[core_idx] : 32'h0;

    if (core_active) begin
      if (!addr_ok) begin
        err_d = 1'b1;
      end else if (mem_we) begin
        ram_we = 1'b1;
      end
    end

    case (state_q)
      S_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          ram_we    = 1'b1;
          ram_waddr = ld_waddr;
          ram_wdata = ld_data;
          if (ld_cnt_q == 5'd18) begin
            ld_cnt_d = 5'd0;
            state_d  = S_START;
          end else begin
            ld_cnt_d = ld_cnt_q + 5'd1;
          end
        end
      end
      S_START: begin
        err_d   = 1'b0;
        state_d = S_ARM;
      end
      S_ARM: begin
        // The core keeps done high from the previous job until restarted.
        if (!core_done) state_d = S_RUN;
      end
      S_RUN: begin
        if (core_done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // rd_valid_q low = fetch cycle, high = present cycle.
        if (!rd_valid_q) begin
          rd_data_d  = ram[dr_raddr];
          rd_index_d = dr_cnt_q[3:0];
          rd_valid_d = 1'b1;
        end else if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (dr_cnt_q == 5'd15) begin
            dr_cnt_d   = 5'd0;
            job_done_d = 1'b1;
            state_d    = S_LOAD;
          end else begin
            dr_cnt_d = dr_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    ld_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d != S_LOAD);
    start_d    = (state_d == S_START);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_LOAD;
      ld_cnt_q   <= 5'd0;
      dr_cnt_q   <= 5'd0;
      ld_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0;
      rd_index_q <= 4'd0;
      job_done_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      mrd_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      dr_cnt_q   <= dr_cnt_d;
      ld_ready_q <= ld_ready_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_index_q <= rd_index_d;
      job_done_q <= job_done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      start_q    <= start_d;
      mrd_q      <= mrd_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  assign ld_ready          = ld_ready_q;
  assign rd_valid          = rd_valid_q;
  assign rd_data           = rd_data_q;
  assign rd_index          = rd_index_q;
  assign job_done          = job_done_q;
  assign busy              = busy_q;
  assign err_addr          = err_q;
  assign core_start        = start_q;
  assign mem_read_data     = mrd_q;
  assign core_message_addr = 16'(MSG_BASE);
  assign core_output_addr  = 16'(OUT_BASE);
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_bitcoin_mem_responder.sv
// Testbench for bitcoin_mem_responder: directed vector table for the core
// port plus randomized jobs checked against a word-array memory model.
module tb_bitcoin_mem_responder;

  localparam int DEPTH    = 64;
  localparam int MSG_BASE = 0;
  localparam int OUT_BASE = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = 32'h0;
  logic        ld_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  rd_index;
  logic        rd_ready = 1'b0;
  logic        job_done;
  logic        busy;
  logic        err_addr;
  logic        core_start;
  logic        core_done = 1'b0;
  logic [15:0] core_message_addr;
  logic [15:0] core_output_addr;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  logic [31:0] mem_write_data = 32'h0;
  logic [31:0] mem_read_data;
  logic [2:0]  dbg_state;

  bitcoin_mem_responder #(.DEPTH(DEPTH), .MSG_BASE(MSG_BASE), .OUT_BASE(OUT_BASE)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index), .rd_ready(rd_ready),
    .job_done(job_done), .busy(busy), .err_addr(err_addr),
    .core_start(core_start), .core_done(core_done),
    .core_message_addr(core_message_addr), .core_output_addr(core_output_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_vld [DEPTH];
  bit          m_err = 1'b0;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tab [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One core cycle of the memory model: read returns the pre-write word,
  // writes and errors only count while the job is running (ARM/RUN).
  task automatic model_step(input bit we, input logic [15:0] addr, input logic [31:0] wd,
                            input bit active, output logic [31:0] exp_rd, output bit exp_def);
    int a;
    a = int'(addr);
    if (a < DEPTH) begin
      exp_rd  = m_mem[a];
      exp_def = m_vld[a];
    end else begin
      exp_rd  = 32'h0;
      exp_def = 1'b1;
    end
    if (active && we && a < DEPTH) begin
      m_mem[a] = wd;
      m_vld[a] = 1'b1;
    end
    if (active && a >= DEPTH) m_err = 1'b1;
  endtask

  task automatic rand_op(output bit we, output logic [15:0] addr, output logic [31:0] wd);
    we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) addr = 16'(DEPTH + $urandom_range(0, 65000));
    else                            addr = 16'($urandom_range(0, DEPTH - 1));
    wd = $urandom;
  endtask

  // Drive one core-port cycle and check the registered result after the edge.
  task automatic bus_cycle(input bit we, input logic [15:0] addr, input logic [31:0] wd,
                           input bit done, input bit active);
    logic [31:0] e;
    bit          d;
    mem_we = we; mem_addr = addr; mem_write_data = wd; core_done = done;
    rd_ready = 1'($urandom_range(0, 1));
    ld_valid = active ? 1'($urandom_range(0, 1)) : 1'b0;
    ld_data  = $urandom;
    if (active) chk("ld_ready_run", ld_ready, 32'd0);
    model_step(we, addr, wd, active, e, d);
    tick();
    if (d) chk("mem_read_data", mem_read_data, e);
    chk("err_addr", err_addr, 32'(m_err));
    if (active) chk("rd_valid_run", rd_valid, 32'd0);
  endtask

  task automatic load_header(input logic [31:0] w [19], input bit gaps);
    int          cnt;
    bit          v;
    bit          we;
    logic [15:0] a;
    logic [31:0] wd;
    logic [31:0] e;
    bit          d;
    cnt = 0;
    while (cnt < 19) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      rand_op(we, a, wd);
      ld_valid = v;
      ld_data  = v ? w[cnt] : $urandom;
      mem_we = we; mem_addr = a; mem_write_data = wd;
      chk("ld_ready_load", ld_ready, 32'd1);
      chk("core_start_load", core_start, 32'd0);
      chk("busy_load", busy, 32'd0);
      model_step(we, a, wd, 1'b0, e, d);
      if (v) begin
        m_mem[MSG_BASE + cnt] = w[cnt];
        m_vld[MSG_BASE + cnt] = 1'b1;
        cnt++;
      end
      tick();
      if (d) chk("mem_read_data_load", mem_read_data, e);
      chk("err_addr_load", err_addr, 32'(m_err));
    end
    ld_valid = 1'b0;
    // START cycle
    chk("core_start_pulse", core_start, 32'd1);
    chk("ld_ready_start", ld_ready, 32'd0);
    chk("busy_start", busy, 32'd1);
    mem_we = 1'b0; mem_addr = 16'($urandom_range(0, 18)); mem_write_data = $urandom;
    model_step(1'b0, mem_addr, 32'h0, 1'b0, e, d);
    m_err = 1'b0;
    tick();
    if (d) chk("mem_read_data_start", mem_read_data, e);
    chk("err_cleared", err_addr, 32'd0);
    chk("core_start_once", core_start, 32'd0);
  endtask

  task automatic core_phase(input int stale, input int nops);
    bit          we;
    logic [15:0] a;
    logic [31:0] wd;
    for (int s = 0; s < stale; s++) begin
      rand_op(we, a, wd);
      bus_cycle(we, a, wd, 1'b1, 1'b1);
    end
    for (int n = 0; n < nops; n++) begin
      rand_op(we, a, wd);
      bus_cycle(we, a, wd, 1'b0, 1'b1);
    end
    for (int i = 0; i < 16; i++) bus_cycle(1'b1, 16'(OUT_BASE + i), $urandom, (i == 15), 1'b1);
  endtask

  task automatic drain(input int stall_idx, input int stall_len, input bit rnd_bp, input int abort_idx);
    int waits;
    for (int idx = 0; idx < 16; idx++) begin
      // fetch cycle: stray host/core traffic must have no effect
      rd_ready = 1'($urandom_range(0, 1));
      ld_valid = 1'b1; ld_data = $urandom;
      mem_we = 1'b1; mem_addr = 16'(OUT_BASE + $urandom_range(0, 15)); mem_write_data = $urandom;
      chk("rd_valid_fetch", rd_valid, 32'd0);
      chk("busy_drain", busy, 32'd1);
      chk("ld_ready_drain", ld_ready, 32'd0);
      tick();
      if (idx == abort_idx) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_rd_valid", rd_valid, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_ld_ready", ld_ready, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_mem_read_data", mem_read_data, 32'd0);
        ld_valid = 1'b0; mem_we = 1'b0; rd_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        m_err = 1'b0;
        tick();
        chk("ld_ready_after_rst", ld_ready, 32'd1);
        return;
      end
      if (idx == stall_idx) waits = stall_len;
      else                  waits = rnd_bp ? $urandom_range(0, 3) : 0;
      for (int c = 0; c <= waits; c++) begin
        chk("rd_valid_present", rd_valid, 32'd1);
        chk($sformatf("rd_data_%0d", idx), rd_data, m_mem[OUT_BASE + idx]);
        chk("rd_index", 32'(rd_index), 32'(idx));
        rd_ready = (c == waits);
        ld_valid = 1'b1; ld_data = $urandom;
        mem_we = 1'b1; mem_addr = 16'(OUT_BASE + $urandom_range(0, 15)); mem_write_data = $urandom;
        tick();
      end
    end
    chk("job_done_pulse", job_done, 32'd1);
    chk("ld_ready_after_job", ld_ready, 32'd1);
    chk("busy_after_job", busy, 32'd0);
    chk("rd_valid_after_job", rd_valid, 32'd0);
    rd_ready = 1'b0; ld_valid = 1'b0; mem_we = 1'b0;
    tick();
    chk("job_done_once", job_done, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] hw [19];
    logic [31:0] e;
    bit          d;

    tab[0] = '{1'b0, 16'd0,      32'h0,        1'b1, 32'h0,  1'b0};
    tab[1] = '{1'b0, 16'd1,      32'h0,        1'b1, 32'h1,  1'b0};
    tab[2] = '{1'b0, 16'd2,      32'h0,        1'b1, 32'h2,  1'b0};
    tab[3] = '{1'b1, 16'd70,     32'hDEADBEEF, 1'b1, 32'h0,  1'b1};
    tab[4] = '{1'b0, 16'd6,      32'h0,        1'b1, 32'h6,  1'b1};
    tab[5] = '{1'b1, 16'd20,     32'h55,       1'b0, 32'h0,  1'b1};
    tab[6] = '{1'b0, 16'd20,     32'h0,        1'b1, 32'h55, 1'b1};
    tab[7] = '{1'b0, 16'd18,     32'h0,        1'b1, 32'h12, 1'b1};
    tab[8] = '{1'b0, 16'hFFFF,   32'h0,        1'b1, 32'h0,  1'b1};

    // reset
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_ld_ready", ld_ready, 32'd0);
    chk("reset_rd_valid", rd_valid, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_rd_index", 32'(rd_index), 32'd0);
    chk("reset_job_done", job_done, 32'd0);
    chk("reset_busy", busy, 32'd0);
    chk("reset_err_addr", err_addr, 32'd0);
    chk("reset_core_start", core_start, 32'd0);
    chk("reset_mem_read_data", mem_read_data, 32'd0);
    chk("core_message_addr", 32'(core_message_addr), 32'(MSG_BASE));
    chk("core_output_addr", 32'(core_output_addr), 32'(OUT_BASE));
    reset_n = 1'b1;
    tick();
    chk("ld_ready_first", ld_ready, 32'd1);

    // job 1: header 0..18 back-to-back, directed core vectors, drain with stall on 3
    for (int i = 0; i < 19; i++) hw[i] = 32'(i);
    load_header(hw, 1'b0);
    for (int k = 0; k < 9; k++) begin
      mem_we = tab[k].we; mem_addr = tab[k].addr; mem_write_data = tab[k].wdata;
      core_done = 1'b0; ld_valid = 1'b0;
      model_step(tab[k].we, tab[k].addr, tab[k].wdata, 1'b1, e, d);
      tick();
      if (tab[k].chk_rd) chk($sformatf("tab%0d_rd", k), mem_read_data, tab[k].exp_rd);
      chk($sformatf("tab%0d_err", k), err_addr, 32'(tab[k].exp_err));
    end
    for (int i = 0; i < 19; i++) bus_cycle(1'b0, 16'(i), 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) bus_cycle(1'b1, 16'(OUT_BASE + i), 32'hA0 + 32'(i), (i == 15), 1'b1);
    drain(3, 5, 1'b0, -1);

    // job 2: core writes during LOAD ignored, stale done holds ARM
    bus_cycle(1'b1, 16'd20, 32'hBAD, 1'b1, 1'b0);
    bus_cycle(1'b0, 16'd20, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++) hw[i] = $urandom;
    load_header(hw, 1'b1);
    core_phase(5, 20);
    drain(-1, 0, 1'b1, -1);

    // jobs 3..5: random; job 5 is reset mid-drain
    for (int j = 3; j <= 5; j++) begin
      for (int i = 0; i < 19; i++) hw[i] = $urandom;
      load_header(hw, 1'b1);
      core_phase($urandom_range(0, 3), $urandom_range(8, 25));
      drain(-1, 0, 1'b1, (j == 5) ? $urandom_range(2, 12) : -1);
    end

    // job 6: counters restart cleanly after the mid-job reset
    for (int i = 0; i < 19; i++) hw[i] = $urandom;
    load_header(hw, 1'b0);
    for (int i = 0; i < 19; i++) bus_cycle(1'b0, 16'(i), 32'h0, 1'b0, 1'b1);
    core_phase(0, 5);
    drain(-1, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
